// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / exception controller.
//
// Holds pipeline stages while any stage requests a stall, redirects fetch on
// a committed exception or exception return, and flags a stall that has
// persisted for STALL_LIMIT consecutive cycles.
//
// Ports:
//   clk           sole clock, rising-edge
//   rst           asynchronous active-high reset
//   stallreq_id   decode stage stall request
//   stallreq_ex   execute stage stall request (multi-cycle op)
//   stallreq_mem  memory stage stall request (bus wait)
//   exc_valid     exception committed in memory stage
//   exc_eret      exception return committed in memory stage
//   exc_epc       return address used by exc_eret
//   stall[5:0]    per-stage hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
//   flush         one-cycle pipeline clear / fetch redirect
//   new_pc        redirect target, valid while flush=1
//   stall_timeout sticky: stall held for STALL_LIMIT consecutive cycles
module pipe_ctrl #(
    parameter logic [7:0]  STALL_LIMIT = 8'd255,
    parameter logic [31:0] EXC_BASE    = 32'h00000020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_eret,
    input  logic [31:0] exc_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  stall_cnt;
    logic [7:0]  stall_cnt_inc;
    logic        any_req;
    logic        exc_any;
    logic        stall_active;

    assign any_req       = stallreq_id | stallreq_ex | stallreq_mem;
    assign exc_any       = exc_valid | exc_eret;
    assign stall_cnt_inc = stall_cnt + 8'd1;
    assign stall_active  = (stall != 6'b000000);

    // flush decodes the state register directly, so it is glitch-free and
    // lands one cycle after the edge that sampled the exception.
    assign flush = (state == S_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational stall vector. The stall vector is
    // forced to zero during reset because state already reads RUN there and
    // would otherwise pass requests straight through.
    always_comb begin
        state_nxt = state;
        stall     = 6'b000000;

        if (state != S_FLUSH) begin
            if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
        if (rst) begin
            stall = 6'b000000;
        end

        case (state)
            S_RUN, S_STALL: begin
                if (exc_any) begin
                    state_nxt = S_FLUSH;
                end else if (any_req) begin
                    state_nxt = S_STALL;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_pc <= '0;
        end else if ((state != S_FLUSH) && exc_any) begin
            new_pc <= exc_valid ? EXC_BASE : exc_epc;
        end
    end

    // Consecutive-stall counter: saturates rather than wrapping, and the
    // timeout fires only on the increment that reaches the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (stall_active) begin
            if (stall_cnt != 8'hFF) begin
                stall_cnt <= stall_cnt_inc;
                if (stall_cnt_inc == STALL_LIMIT) begin
                    stall_timeout <= 1'b1;
                end
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (STALL_LIMIT = 4).
module tb_pipe_ctrl;

    localparam logic [7:0]  LIMIT = 8'd4;
    localparam logic [31:0] EBASE = 32'h00000020;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_valid;
    logic        exc_eret;
    logic [31:0] exc_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    pipe_ctrl #(
        .STALL_LIMIT (LIMIT),
        .EXC_BASE    (EBASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .exc_valid     (exc_valid),
        .exc_eret      (exc_eret),
        .exc_epc       (exc_epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_tests;
    int unsigned n_fail;

    // Reference model: 0 = RUN, 1 = STALL, 2 = FLUSH
    int          m_state;
    logic [31:0] m_pc;
    logic [7:0]  m_cnt;
    logic        m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_cnt   = '0;
        m_to    = 1'b0;
    endtask

    function automatic logic [5:0] model_stall(input logic id, input logic ex, input logic mem);
        if (m_state == 2) return 6'b000000;
        if (mem) return 6'b011111;
        if (ex)  return 6'b001111;
        if (id)  return 6'b000111;
        return 6'b000000;
    endfunction

    // Drive one cycle of inputs (called just after a negedge), push the
    // model's expectation, compare the DUT mid-cycle, then advance the model
    // across the rising edge.
    task automatic step(input logic id, input logic ex, input logic mem,
                        input logic ev, input logic er, input logic [31:0] epc);
        exp_t e;
        exp_t p;
        logic [5:0] es;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        exc_valid    = ev;
        exc_eret     = er;
        exc_epc      = epc;
        es        = model_stall(id, ex, mem);
        e.stall   = es;
        e.flush   = (m_state == 2);
        e.new_pc  = m_pc;
        e.timeout = m_to;
        exp_q.push_back(e);
        #1;
        p = exp_q.pop_front();
        check("stall",   {26'd0, stall},          {26'd0, p.stall});
        check("flush",   {31'd0, flush},          {31'd0, p.flush});
        check("new_pc",  new_pc,                  p.new_pc);
        check("timeout", {31'd0, stall_timeout},  {31'd0, p.timeout});
        @(posedge clk);
        if (es != 6'b000000) begin
            if (m_cnt != 8'hFF) begin
                m_cnt = m_cnt + 8'd1;
                if (m_cnt == LIMIT) m_to = 1'b1;
            end
        end else begin
            m_cnt = 8'd0;
        end
        if (m_state != 2 && (ev || er)) begin
            m_state = 2;
            m_pc    = ev ? EBASE : epc;
        end else if (m_state == 2) begin
            m_state = 0;
        end else begin
            m_state = (id || ex || mem) ? 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, ".stall"},   {26'd0, stall},         32'd0);
        check({tag, ".flush"},   {31'd0, flush},         32'd0);
        check({tag, ".new_pc"},  new_pc,                 32'd0);
        check({tag, ".timeout"}, {31'd0, stall_timeout}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst          = 1'b1;
        stallreq_id  = 1'b1;
        stallreq_ex  = 1'b1;
        stallreq_mem = 1'b1;
        exc_valid    = 1'b0;
        exc_eret     = 1'b0;
        exc_epc      = '0;

        // Reset state, with requests asserted to show stall is gated off
        @(negedge clk);
        @(negedge clk);
        check_all_clear("reset");
        rst = 1'b0;

        // Three-cycle execute stall
        repeat (3) step(0, 1, 0, 0, 0, 32'h0);
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // id+mem together, then mem drops within the stall
        repeat (2) step(1, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);

        // Exception during a memory stall
        step(0, 0, 1, 1, 0, 32'h0);
        check("exc_flush_pc_direct", m_pc, EBASE);
        repeat (2) step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);

        // eret, then exc_valid during the FLUSH cycle is ignored
        step(0, 0, 0, 0, 1, 32'h00400104);
        step(0, 0, 0, 1, 0, 32'h0);
        check("eret_pc_direct", new_pc, 32'h00400104);
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // Both exception sources on the same edge: base address wins
        step(1, 0, 0, 1, 1, 32'hDEADBEEC);
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // Stall timeout: ex held 6 cycles with limit 4, sticky after drop
        repeat (6) step(0, 1, 0, 0, 0, 32'h0);
        repeat (3) step(0, 0, 0, 0, 0, 32'h0);
        check("timeout_sticky_direct", {31'd0, stall_timeout}, 32'd1);

        // Source change ex -> mem keeps counting
        repeat (2) step(0, 1, 0, 0, 0, 32'h0);
        repeat (3) step(0, 0, 1, 0, 0, 32'h0);

        // Asynchronous reset between edges while stalled with timeout set,
        // an exception pending on the inputs
        stallreq_mem = 1'b1;
        exc_valid    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_clear("async_rst");
        model_reset();
        exc_valid    = 1'b0;
        stallreq_mem = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(0, 0, 0, 0, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), $urandom);
        end

        if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
